// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
package div_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } div_state_e;

   localparam int DIV_WIDTH = 32;

   // Quotient reported when the divisor is zero.
   localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = {DIV_WIDTH{1'b1}};

endpackage

// File: rtl/div_sub_step.sv
// rtl/div_sub_step.sv - one restoring trial subtract, combinational
module div_sub_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_shift_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_next_o,
   output logic             qbit_o
);

   logic [WIDTH+1:0] sum;
   logic             sum_unused;

   // a - d as a + ~d + 1; carry-out set means a >= d (no borrow)
   assign sum        = {1'b0, rem_shift_i} + {1'b0, ~{1'b0, divisor_i}} + {{(WIDTH+1){1'b0}}, 1'b1};
   assign qbit_o     = sum[WIDTH+1];
   assign rem_next_o = qbit_o ? sum[WIDTH-1:0] : rem_shift_i[WIDTH-1:0];
   assign sum_unused = sum[WIDTH];

endmodule

// File: rtl/div32_seq.sv
// rtl/div32_seq.sv - iterative unsigned restoring divider, one quotient bit per clock
module div32_seq
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] DIVIDEND,
   input  logic [WIDTH-1:0] DIVISOR,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] QUOTIENT,
   output logic [WIDTH-1:0] REMAINDER,
   output logic             DIV_BY_ZERO
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   div_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] d_q, q_q, r_q;
   logic [WIDTH-1:0] quot_q, rem_q;
   logic             busy_q, done_q, dbz_q, dbz_pend_q;
   logic [WIDTH-1:0] r_d, q_d;
   logic             qbit;

   div_sub_step #(.WIDTH(WIDTH)) u_step (
      .rem_shift_i (({r_q, q_q[WIDTH-1]})),
      .divisor_i   (d_q),
      .rem_next_o  (r_d),
      .qbit_o      (qbit)
   );

   assign q_d = {q_q[WIDTH-2:0], qbit};

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         d_q        <= '0;
         q_q        <= '0;
         r_q        <= '0;
         quot_q     <= '0;
         rem_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         dbz_q      <= 1'b0;
         dbz_pend_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // A zero divisor reports one edge after acceptance without entering RUN.
               if (dbz_pend_q) begin
                  quot_q     <= {WIDTH{1'b1}};
                  rem_q      <= q_q;
                  dbz_q      <= 1'b1;
                  done_q     <= 1'b1;
                  dbz_pend_q <= 1'b0;
               end else if (START) begin
                  q_q <= DIVIDEND;
                  if (DIVISOR != '0) begin
                     d_q     <= DIVISOR;
                     r_q     <= '0;
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                     state_q <= RUN;
                  end else begin
                     dbz_pend_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               r_q   <= r_d;
               q_q   <= q_d;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  quot_q  <= q_d;
                  rem_q   <= r_d;
                  dbz_q   <= 1'b0;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign BUSY        = busy_q;
   assign DONE        = done_q;
   assign QUOTIENT    = quot_q;
   assign REMAINDER   = rem_q;
   assign DIV_BY_ZERO = dbz_q;

endmodule

// File: tb/tb_div32_seq.sv
// tb/tb_div32_seq.sv - self-checking bench for div32_seq
module tb_div32_seq;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        START = 1'b0;
   logic [31:0] DIVIDEND = '0;
   logic [31:0] DIVISOR = '0;
   logic        BUSY, DONE, DIV_BY_ZERO;
   logic [31:0] QUOTIENT, REMAINDER;

   div32_seq dut (
      .CLK(CLK), .RST(RST), .START(START), .DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR),
      .BUSY(BUSY), .DONE(DONE), .QUOTIENT(QUOTIENT), .REMAINDER(REMAINDER),
      .DIV_BY_ZERO(DIV_BY_ZERO)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] dividend;
      logic [31:0] divisor;
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
   } vec_t;

   typedef struct {
      logic [31:0] dividend;
      logic [31:0] divisor;
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      int          exp_cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   busy_cnt = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (RST) begin
         busy_cnt = 0;
      end else begin
         if (BUSY) busy_cnt++;
         if (DONE) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("latency", 64'(cyc), 64'(e.exp_cyc));
               check("quotient", 64'(QUOTIENT), 64'(e.q));
               check("remainder", 64'(REMAINDER), 64'(e.r));
               check("div_by_zero", 64'(DIV_BY_ZERO), 64'(e.dbz));
               check("busy_cycles", 64'(busy_cnt), e.dbz ? 64'd0 : 64'd32);
               if (!e.dbz) begin
                  check("identity", 64'(QUOTIENT) * 64'(e.divisor) + 64'(REMAINDER), 64'(e.dividend));
                  check("rem_lt_div", 64'(REMAINDER < e.divisor), 64'd1);
               end
            end
            busy_cnt = 0;
         end
      end
   end

   function automatic exp_t mk_exp(input vec_t v, input int now);
      exp_t e;
      e.dividend = v.dividend;
      e.divisor  = v.divisor;
      e.q        = v.q;
      e.r        = v.r;
      e.dbz      = v.dbz;
      e.exp_cyc  = now + 1 + ((v.divisor == 0) ? 1 : 32);
      return e;
   endfunction

   task automatic issue(input vec_t v, input bit push);
      @(negedge CLK);
      DIVIDEND = v.dividend;
      DIVISOR  = v.divisor;
      START    = 1'b1;
      if (push) sb.push_back(mk_exp(v, cyc));
      @(negedge CLK);
      START = 1'b0;
   endtask

   task automatic wait_empty(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(posedge CLK);
         #2;
         n++;
      end
      if (sb.size() != 0) begin
         check({name, "_timeout"}, 64'(sb.size()), 64'd0);
         sb.delete();
      end
   endtask

   function automatic vec_t model(input logic [31:0] a, input logic [31:0] b);
      vec_t v;
      v.dividend = a;
      v.divisor  = b;
      v.dbz      = (b == 0);
      v.q        = (b == 0) ? 32'hFFFF_FFFF : a / b;
      v.r        = (b == 0) ? a : a % b;
      return v;
   endfunction

   initial begin
      vec_t vecs[6];
      vec_t v;
      int   n;
      vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
      vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
      vecs[2] = '{32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
      vecs[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};
      vecs[4] = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
      vecs[5] = '{32'hDEAD_BEEF,  32'h0001_0000,  32'h0000_DEAD,  32'h0000_BEEF,  1'b0};

      repeat (3) @(negedge CLK);
      check("reset_busy", 64'(BUSY), 64'd0);
      check("reset_done", 64'(DONE), 64'd0);
      check("reset_quotient", 64'(QUOTIENT), 64'd0);
      check("reset_remainder", 64'(REMAINDER), 64'd0);
      check("reset_dbz", 64'(DIV_BY_ZERO), 64'd0);
      RST = 1'b0;

      for (int i = 0; i < 6; i++) begin
         issue(vecs[i], 1'b1);
         wait_empty("vector");
         repeat (2) @(negedge CLK);
      end

      // Ignored START mid-divide
      issue(model(32'd1234567, 32'd89), 1'b1);
      repeat (9) @(negedge CLK);
      DIVIDEND = 32'd55;
      DIVISOR  = 32'd5;
      START    = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      check("busy_during_ignored_start", 64'(BUSY), 64'd1);
      wait_empty("ignored_start");
      repeat (3) @(negedge CLK);

      // Reset abandons a divide in flight
      issue(model(32'd100, 32'd7), 1'b0);
      repeat (9) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      check("rst_busy", 64'(BUSY), 64'd0);
      check("rst_done", 64'(DONE), 64'd0);
      check("rst_quotient", 64'(QUOTIENT), 64'd0);
      check("rst_remainder", 64'(REMAINDER), 64'd0);
      check("rst_dbz", 64'(DIV_BY_ZERO), 64'd0);
      repeat (40) @(negedge CLK);
      issue(model(32'd9, 32'd4), 1'b1);
      wait_empty("after_reset");
      repeat (2) @(negedge CLK);

      // Back-to-back issue in the DONE cycle
      issue(model(32'd1000, 32'd3), 1'b1);
      n = 0;
      while (!DONE && n < 40) begin
         @(negedge CLK);
         n++;
      end
      check("b2b_first_done_seen", 64'(DONE), 64'd1);
      v = model(32'd7, 32'd7);
      DIVIDEND = v.dividend;
      DIVISOR  = v.divisor;
      START    = 1'b1;
      sb.push_back(mk_exp(v, cyc));
      @(negedge CLK);
      START = 1'b0;
      wait_empty("back_to_back");
      repeat (2) @(negedge CLK);

      for (int i = 0; i < 20; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         issue(model(a, b), 1'b1);
         wait_empty("random");
      end

      repeat (3) @(negedge CLK);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
